oam_dma_ctrl: RTL

- Sequences OAM DMA for the sm83 core and arbitrates the shared main memory bus between the CPU and the DMA engine.
- A CPU write to register 0xFF46 starts a copy of DMA_LEN bytes from {src_hi,8'h00} to OAM, one byte per clk.
- Sits between the core's memory interface and the system bus. It owns the 0xFF46 register, the HRAM routing, and a dedicated OAM write port.

---
 rtl/oam_dma_ctrl_pkg.sv | 22 ++
 rtl/oam_dma_ctrl_if.sv | 37 +++
 rtl/oam_dma_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared types and constants for the OAM DMA controller.
// Optional build macro used by the controller: OAM_DMA_CPU_BLOCK_EN.
package oam_dma_ctrl_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER,
    DMA_DRAIN
  } dma_state_t;

  localparam logic [15:0] HRAM_BASE      = 16'hFF80;
  localparam logic [15:0] HRAM_TOP       = 16'hFFFE;
  localparam logic [15:0] OAM_BASE       = 16'hFE00;
  localparam logic [7:0]  ECHO_FOLD_MASK = 8'hDF;

  // Pages E0-FF mirror C0-DF, so the source page is folded down.
  function automatic logic [7:0] fold_src_hi(input logic [7:0] reg_val);
    return (reg_val >= 8'hE0) ? (reg_val & ECHO_FOLD_MASK) : reg_val;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side, system-bus, HRAM and OAM signals of the OAM DMA controller.
// master = the controller, slave = the surrounding system.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic [6:0]  hram_addr;
  logic        hram_rd;
  logic        hram_wr;
  logic [7:0]  hram_wdata;
  logic [7:0]  hram_rdata;
  logic [7:0]  oam_addr;
  logic        oam_we;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  modport master (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, bus_rdata, hram_rdata,
    output cpu_rdata, bus_addr, bus_rd, bus_wr, bus_wdata,
           hram_addr, hram_rd, hram_wr, hram_wdata,
           oam_addr, oam_we, oam_wdata, dma_active
  );

  modport slave (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, bus_rdata, hram_rdata,
    input  cpu_rdata, bus_addr, bus_rd, bus_wr, bus_wdata,
           hram_addr, hram_rd, hram_wr, hram_wdata,
           oam_addr, oam_we, oam_wdata, dma_active
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA sequencer and CPU/DMA bus arbiter. Define OAM_DMA_CPU_BLOCK_EN to give
// the DMA absolute bus ownership during XFER; otherwise the CPU wins and the DMA stalls.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter int          DMA_LEN      = 160,
  parameter int          START_DELAY  = 1,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input logic            clk,
  input logic            rst_n,
  oam_dma_ctrl_if.master io
);

  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(START_DELAY - 1);
  localparam logic [7:0]       IDX_LAST = 8'(DMA_LEN - 1);

  dma_state_t       state_reg;
  logic [7:0]       dma_reg;
  logic [7:0]       idx_reg;
  logic [DLY_W-1:0] dly_reg;
  logic             pend_valid_reg;
  logic [7:0]       pend_idx_reg;
  logic [7:0]       pend_data_reg;
  logic             active_reg;

  logic       is_hram, is_dreg, cpu_rd_eff, cpu_bus_req, cpu_bus_grant;
  logic       in_xfer, dma_go, dreg_wr;
  logic [7:0] src_hi;

  assign src_hi = fold_src_hi(dma_reg);

  always_comb begin
    is_hram     = (io.cpu_addr >= HRAM_BASE) && (io.cpu_addr <= HRAM_TOP);
    is_dreg     = (io.cpu_addr == DMA_REG_ADDR);
    cpu_rd_eff  = io.cpu_rd & ~io.cpu_wr;
    cpu_bus_req = (io.cpu_rd | io.cpu_wr) & ~is_hram & ~is_dreg;
    in_xfer     = (state_reg == DMA_XFER);
    dreg_wr     = io.cpu_wr & is_dreg;
`ifdef OAM_DMA_CPU_BLOCK_EN
    cpu_bus_grant = cpu_bus_req & ~in_xfer;
    dma_go        = in_xfer;
`else
    cpu_bus_grant = cpu_bus_req;
    dma_go        = in_xfer & ~cpu_bus_req;
`endif

    io.bus_addr  = io.cpu_addr;
    io.bus_rd    = 1'b0;
    io.bus_wr    = 1'b0;
    io.bus_wdata = io.cpu_wdata;
    if (dma_go) begin
      io.bus_addr = {src_hi, idx_reg};
      io.bus_rd   = 1'b1;
    end else if (cpu_bus_grant) begin
      io.bus_rd = cpu_rd_eff;
      io.bus_wr = io.cpu_wr;
    end

    // HRAM starts on a 128-byte boundary, so the offset is the low address bits.
    io.hram_addr  = io.cpu_addr[6:0];
    io.hram_rd    = is_hram & cpu_rd_eff;
    io.hram_wr    = is_hram & io.cpu_wr;
    io.hram_wdata = io.cpu_wdata;

    io.cpu_rdata = 8'hFF;
    if (cpu_rd_eff) begin
      if (is_hram)            io.cpu_rdata = io.hram_rdata;
      else if (is_dreg)       io.cpu_rdata = dma_reg;
      else if (cpu_bus_grant) io.cpu_rdata = io.bus_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= DMA_IDLE;
      dma_reg        <= 8'h00;
      idx_reg        <= 8'h00;
      dly_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_idx_reg   <= 8'h00;
      pend_data_reg  <= 8'h00;
      active_reg     <= 1'b0;
    end else begin
      pend_valid_reg <= dma_go;
      if (dma_go) begin
        pend_data_reg <= io.bus_rdata;
        pend_idx_reg  <= idx_reg;
      end
      case (state_reg)
        DMA_IDLE: ;
        DMA_START: begin
          dly_reg <= dly_reg + 1'b1;
          if (dly_reg == DLY_LAST) state_reg <= DMA_XFER;
        end
        DMA_XFER: begin
          if (dma_go) begin
            idx_reg <= idx_reg + 8'd1;
            if (idx_reg == IDX_LAST) state_reg <= DMA_DRAIN;
          end
        end
        DMA_DRAIN: begin
          state_reg  <= DMA_IDLE;
          active_reg <= 1'b0;
        end
        default: state_reg <= DMA_IDLE;
      endcase
      // A trigger write (re)starts the sequence from any state.
      if (dreg_wr) begin
        dma_reg    <= io.cpu_wdata;
        idx_reg    <= 8'h00;
        dly_reg    <= '0;
        state_reg  <= DMA_START;
        active_reg <= 1'b1;
      end
    end
  end

  assign io.oam_we     = pend_valid_reg;
  assign io.oam_addr   = pend_idx_reg;
  assign io.oam_wdata  = pend_data_reg;
  assign io.dma_active = active_reg;

endmodule
